// File: rtl/modbus_pkg.sv
// Shared constants and state encoding for the Modbus RTU response framer.
package modbus_pkg;
  localparam logic [7:0]  FC_RD_HOLD       = 8'h03;
  localparam logic [7:0]  FC_RD_INPUT      = 8'h04;
  localparam logic [7:0]  FC_WR_SINGLE     = 8'h06;
  localparam logic [7:0]  FC_WR_MULTI      = 8'h10;
  localparam logic [7:0]  EXC_ILLEGAL_FUNC = 8'h01;
  localparam logic [7:0]  EXC_ILLEGAL_VAL  = 8'h03;
  localparam logic [15:0] CRC_INIT         = 16'hFFFF;
  localparam logic [15:0] CRC_POLY         = 16'hA001;

  typedef enum logic [3:0] {
    IDLE, LOAD, HDR, FETCH, REG_HI, REG_LO, CRC_LO, CRC_HI, DONE
  } state_t;
endpackage

// File: rtl/modbus_crc16_byte.sv
// One-byte CRC-16/Modbus update, LSB-first with the reflected polynomial.
module modbus_crc16_byte
  import modbus_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [7:0]  byte_in,
  output logic [15:0] crc_out
);
  logic [15:0] c;
  always_comb begin
    c = crc_in ^ {8'h00, byte_in};
    for (int i = 0; i < 8; i++)
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    crc_out = c;
  end
endmodule

// File: rtl/modbus_tx_framer.sv
// Builds a Modbus RTU response frame (header, register payload, CRC) and streams it byte by byte.
module modbus_tx_framer
  import modbus_pkg::*;
#(
  parameter logic [7:0] SADDR    = 8'h01,
  parameter int         MAX_REGS = 16
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        handler_done,
  input  logic [7:0]  exception,
  input  logic [7:0]  func_code,
  input  logic [15:0] addr,
  input  logic [15:0] data,
  input  logic [7:0]  quantity,
  output logic        reg_rd_en,
  output logic [7:0]  reg_rd_idx,
  input  logic [15:0] reg_rd_data,
  output logic [7:0]  tx_byte,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        frame_done
);
  state_t      state_q, state_d;
  logic [7:0]  fc_q, exc_q, qty_q, idx_q, exc_eff, hdr_byte;
  logic [15:0] addr_q, data_q, rd_q, crc_q, crc_nxt;
  logic [2:0]  cnt_q, hdr_last;
  logic        fresh_q, xfer, is_read, go_regs, last_reg;

  assign is_read    = (fc_q == FC_RD_HOLD) || (fc_q == FC_RD_INPUT);
  assign go_regs    = (exc_q == 8'h00) && is_read;
  assign last_reg   = (idx_q == qty_q - 8'd1);
  assign xfer       = tx_valid && tx_ready;
  assign reg_rd_idx = idx_q;

  // exc_q holds the raw exception from capture until LOAD folds in the substitutions
  always_comb begin
    exc_eff = exc_q;
    if (exc_q == 8'h00) begin
      if (is_read) begin
        if (qty_q == 8'h00 || int'(qty_q) > MAX_REGS) exc_eff = EXC_ILLEGAL_VAL;
      end else if (fc_q != FC_WR_SINGLE && fc_q != FC_WR_MULTI) begin
        exc_eff = EXC_ILLEGAL_FUNC;
      end
    end
  end

  always_comb begin
    hdr_byte = 8'h00;
    hdr_last = 3'd2;
    if (exc_q != 8'h00 || is_read) begin
      case (cnt_q)
        3'd0:    hdr_byte = SADDR;
        3'd1:    hdr_byte = (exc_q != 8'h00) ? (fc_q | 8'h80) : fc_q;
        default: hdr_byte = (exc_q != 8'h00) ? exc_q : {qty_q[6:0], 1'b0};
      endcase
    end else begin
      hdr_last = 3'd5;
      case (cnt_q)
        3'd0:    hdr_byte = SADDR;
        3'd1:    hdr_byte = fc_q;
        3'd2:    hdr_byte = addr_q[15:8];
        3'd3:    hdr_byte = addr_q[7:0];
        3'd4:    hdr_byte = (fc_q == FC_WR_MULTI) ? 8'h00 : data_q[15:8];
        default: hdr_byte = (fc_q == FC_WR_MULTI) ? qty_q : data_q[7:0];
      endcase
    end
  end

  modbus_crc16_byte u_crc (.crc_in(crc_q), .byte_in(tx_byte), .crc_out(crc_nxt));

  always_comb begin
    state_d    = state_q;
    tx_byte    = 8'h00;
    tx_valid   = 1'b0;
    reg_rd_en  = 1'b0;
    busy       = (state_q != IDLE);
    frame_done = 1'b0;
    unique case (state_q)
      IDLE:  if (handler_done) state_d = LOAD;
      LOAD:  state_d = HDR;
      HDR: begin
        tx_byte  = hdr_byte;
        tx_valid = 1'b1;
        if (tx_ready && cnt_q == hdr_last) state_d = go_regs ? FETCH : CRC_LO;
      end
      FETCH: begin
        reg_rd_en = 1'b1;
        state_d   = REG_HI;
      end
      REG_HI: begin
        // read data is only on the bus in the first REG_HI cycle; after that use the copy
        tx_byte  = fresh_q ? reg_rd_data[15:8] : rd_q[15:8];
        tx_valid = 1'b1;
        if (tx_ready) state_d = REG_LO;
      end
      REG_LO: begin
        tx_byte  = rd_q[7:0];
        tx_valid = 1'b1;
        if (tx_ready) state_d = last_reg ? CRC_LO : FETCH;
      end
      CRC_LO: begin
        tx_byte  = crc_q[7:0];
        tx_valid = 1'b1;
        if (tx_ready) state_d = CRC_HI;
      end
      CRC_HI: begin
        tx_byte  = crc_q[15:8];
        tx_valid = 1'b1;
        if (tx_ready) state_d = DONE;
      end
      DONE: begin
        frame_done = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= IDLE;
      fc_q    <= 8'h00;
      exc_q   <= 8'h00;
      qty_q   <= 8'h00;
      addr_q  <= 16'h0000;
      data_q  <= 16'h0000;
      rd_q    <= 16'h0000;
      crc_q   <= CRC_INIT;
      cnt_q   <= 3'd0;
      idx_q   <= 8'h00;
      fresh_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fresh_q <= (state_q == FETCH);
      if (fresh_q) rd_q <= reg_rd_data;
      if (state_q == IDLE && handler_done) begin
        fc_q   <= func_code;
        exc_q  <= exception;
        qty_q  <= quantity;
        addr_q <= addr;
        data_q <= data;
      end
      if (state_q == LOAD) begin
        exc_q <= exc_eff;
        cnt_q <= 3'd0;
        idx_q <= 8'h00;
        crc_q <= CRC_INIT;
      end
      if (xfer && (state_q == HDR || state_q == REG_HI || state_q == REG_LO)) crc_q <= crc_nxt;
      if (xfer && state_q == HDR) cnt_q <= cnt_q + 3'd1;
      if (xfer && state_q == REG_LO && !last_reg) idx_q <= idx_q + 8'd1;
    end
  end
endmodule

// File: tb/tb_modbus_tx_framer.sv
// Directed vector bench for modbus_tx_framer: frame bytes, register fetch order, stalls, reset.
module tb_modbus_tx_framer;
  logic        clk_in = 1'b0, rst_n_in = 1'b0, handler_done = 1'b0;
  logic [7:0]  exception = 8'h00, func_code = 8'h00, quantity = 8'h00;
  logic [15:0] addr = 16'h0000, data = 16'h0000, reg_rd_data = 16'h0000;
  logic        tx_ready = 1'b1;
  logic        reg_rd_en, tx_valid, busy, frame_done;
  logic [7:0]  reg_rd_idx, tx_byte;

  modbus_tx_framer dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .handler_done(handler_done),
    .exception(exception), .func_code(func_code), .addr(addr), .data(data),
    .quantity(quantity), .reg_rd_en(reg_rd_en), .reg_rd_idx(reg_rd_idx),
    .reg_rd_data(reg_rd_data), .tx_byte(tx_byte), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [7:0]       exc, fc;
    logic [15:0]      a, d;
    logic [7:0]       q;
    bit               stall, poke;
    int               hlen;
    logic [0:5][7:0]  hdr;
    int               nregs;
  } vec_t;

  vec_t vecs [$];
  logic [7:0] got [$];
  logic [7:0] exp_q [$];
  logic [7:0] idx_log [$];
  int checks = 0, errors = 0;
  int done_cnt, stall_err;
  bit timed_out, late_busy;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  function automatic logic [15:0] reg_val(input logic [7:0] i);
    if (i == 8'd0) return 16'h000A;
    if (i == 8'd1) return 16'h0102;
    return {i, ~i};
  endfunction

  function automatic vec_t mk(input logic [7:0] exc, input logic [7:0] fc, input logic [15:0] a,
                              input logic [15:0] d, input logic [7:0] q, input bit stall, input bit poke,
                              input int hlen, input logic [0:5][7:0] hdr, input int nregs);
    vec_t v;
    v.exc = exc; v.fc = fc; v.a = a; v.d = d; v.q = q; v.stall = stall; v.poke = poke;
    v.hlen = hlen; v.hdr = hdr; v.nregs = nregs;
    return v;
  endfunction

  // expected frame = hand-written header + register payload + CRC-16/Modbus of everything before it
  task automatic build_exp(input vec_t v);
    logic [15:0] c;
    exp_q.delete();
    for (int i = 0; i < v.hlen; i++) exp_q.push_back(v.hdr[i]);
    for (int i = 0; i < v.nregs; i++) begin
      exp_q.push_back(reg_val(8'(i)) >> 8);
      exp_q.push_back(reg_val(8'(i)) & 16'h00FF);
    end
    c = 16'hFFFF;
    foreach (exp_q[k]) begin
      c = c ^ {8'h00, exp_q[k]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    exp_q.push_back(c[7:0]);
    exp_q.push_back(c[15:8]);
  endtask

  task automatic run_frame(input vec_t v);
    int cyc, post;
    logic pend, pstall;
    logic [7:0] pidx, pbyte;
    got.delete(); idx_log.delete();
    done_cnt = 0; stall_err = 0; late_busy = 0;
    @(posedge clk_in); #1;
    exception = v.exc; func_code = v.fc; addr = v.a; data = v.d; quantity = v.q;
    handler_done = 1'b1; tx_ready = 1'b1;
    @(posedge clk_in); #1;
    handler_done = 1'b0;
    exception = 8'hEE; func_code = 8'h06; addr = 16'hBEEF; data = 16'hCAFE; quantity = 8'hFF;
    pend = 0; pstall = 0; pidx = 0; pbyte = 0; post = 0; cyc = 0;
    while (post < 3 && cyc < 600) begin
      reg_rd_data  = pend ? reg_val(pidx) : 16'hDEAD;
      tx_ready     = v.stall ? 1'($urandom_range(0, 1)) : 1'b1;
      handler_done = v.poke && (cyc == 20);
      @(negedge clk_in);
      if (pstall && (!tx_valid || tx_byte !== pbyte)) stall_err++;
      pstall = tx_valid && !tx_ready;
      pbyte  = tx_byte;
      pend   = reg_rd_en;
      pidx   = reg_rd_idx;
      if (reg_rd_en) idx_log.push_back(reg_rd_idx);
      if (tx_valid && tx_ready) got.push_back(tx_byte);
      if (frame_done) done_cnt++;
      if (done_cnt > 0) begin
        if (post > 0 && busy) late_busy = 1;
        post++;
      end
      @(posedge clk_in); #1;
      cyc++;
    end
    handler_done = 1'b0; tx_ready = 1'b1;
    timed_out = (post < 3);
  endtask

  task automatic check_bytes(input string nm);
    int bad;
    bad = -1;
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      if (bad < 0 && got[i] !== exp_q[i]) bad = i;
    chk({nm, "_len"}, got.size(), exp_q.size());
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s_bytes: byte %0d got %0h expected %0h", nm, bad, got[bad], exp_q[bad]);
    end
  endtask

  task automatic check_frame(input vec_t v, input string nm);
    int bad_idx;
    build_exp(v);
    chk({nm, "_timeout"}, timed_out, 0);
    check_bytes(nm);
    chk({nm, "_frame_done"}, done_cnt, 1);
    chk({nm, "_busy_after"}, late_busy, 0);
    chk({nm, "_rd_count"}, idx_log.size(), v.nregs);
    bad_idx = 0;
    foreach (idx_log[i]) if (idx_log[i] !== 8'(i)) bad_idx++;
    chk({nm, "_rd_order"}, bad_idx, 0);
    if (v.stall) chk({nm, "_stall_hold"}, stall_err, 0);
  endtask

  initial begin
    int n;
    // reset state
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    chk("reset_outs", {tx_valid, tx_byte, reg_rd_en, reg_rd_idx, busy, frame_done}, 0);
    rst_n_in = 1'b1;

    vecs.push_back(mk(8'h00, 8'h06, 16'h0001, 16'h0003, 8'd0,  0, 0, 6, {8'h01,8'h06,8'h00,8'h01,8'h00,8'h03}, 0));
    vecs.push_back(mk(8'h02, 8'h03, 16'h0000, 16'h0000, 8'd2,  0, 0, 3, {8'h01,8'h83,8'h02,8'h00,8'h00,8'h00}, 0));
    vecs.push_back(mk(8'h00, 8'h03, 16'h0000, 16'h0000, 8'd2,  0, 0, 3, {8'h01,8'h03,8'h04,8'h00,8'h00,8'h00}, 2));
    vecs.push_back(mk(8'h00, 8'h03, 16'h0000, 16'h0000, 8'd0,  0, 0, 3, {8'h01,8'h83,8'h03,8'h00,8'h00,8'h00}, 0));
    vecs.push_back(mk(8'h00, 8'h03, 16'h0000, 16'h0000, 8'd17, 0, 0, 3, {8'h01,8'h83,8'h03,8'h00,8'h00,8'h00}, 0));
    vecs.push_back(mk(8'h00, 8'h04, 16'h0000, 16'h0000, 8'd1,  0, 0, 3, {8'h01,8'h04,8'h02,8'h00,8'h00,8'h00}, 1));
    vecs.push_back(mk(8'h00, 8'h10, 16'h1234, 16'hFFFF, 8'd5,  0, 0, 6, {8'h01,8'h10,8'h12,8'h34,8'h00,8'h05}, 0));
    vecs.push_back(mk(8'h00, 8'h05, 16'h0000, 16'h0000, 8'd1,  0, 0, 3, {8'h01,8'h85,8'h01,8'h00,8'h00,8'h00}, 0));
    vecs.push_back(mk(8'h07, 8'h10, 16'h0000, 16'h0000, 8'd1,  0, 0, 3, {8'h01,8'h90,8'h07,8'h00,8'h00,8'h00}, 0));
    vecs.push_back(mk(8'h00, 8'h03, 16'h0000, 16'h0000, 8'd16, 0, 0, 3, {8'h01,8'h03,8'h20,8'h00,8'h00,8'h00}, 16));
    vecs.push_back(mk(8'h00, 8'h03, 16'h0000, 16'h0000, 8'd16, 1, 1, 3, {8'h01,8'h03,8'h20,8'h00,8'h00,8'h00}, 16));
    vecs.push_back(mk(8'h00, 8'h04, 16'h0000, 16'h0000, 8'd16, 1, 0, 3, {8'h01,8'h04,8'h20,8'h00,8'h00,8'h00}, 16));

    foreach (vecs[v]) begin
      run_frame(vecs[v]);
      check_frame(vecs[v], $sformatf("vec%0d", v));
      if (v == 0 && got.size() == 8) chk("fc06_crc", {got[6], got[7]}, 16'h980B);
      if (v == 1 && got.size() == 5) chk("exc02_crc", {got[3], got[4]}, 16'hC0F1);
    end

    // back-to-back: a request in the cycle right after DONE must be taken
    @(posedge clk_in); #1;
    func_code = 8'h06; exception = 8'h00; addr = 16'h0001; data = 16'h0003; handler_done = 1'b1;
    @(posedge clk_in); #1; handler_done = 1'b0;
    n = 0;
    do begin @(negedge clk_in); n++; end while (!frame_done && n < 100);
    chk("b2b_first_done", frame_done, 1);
    @(posedge clk_in); #1;
    addr = 16'h0002; data = 16'h0004; handler_done = 1'b1;
    @(posedge clk_in); #1; handler_done = 1'b0;
    @(negedge clk_in);
    chk("b2b_busy", busy, 1);
    got.delete(); n = 0;
    while (!frame_done && n < 100) begin
      if (tx_valid && tx_ready) got.push_back(tx_byte);
      @(negedge clk_in); n++;
    end
    build_exp(mk(8'h00, 8'h06, 16'h0002, 16'h0004, 8'd0, 0, 0, 6, {8'h01,8'h06,8'h00,8'h02,8'h00,8'h04}, 0));
    check_bytes("b2b_second");

    // reset once three bytes of a read frame have gone out
    @(posedge clk_in); #1;
    func_code = 8'h03; exception = 8'h00; quantity = 8'd4; handler_done = 1'b1;
    @(posedge clk_in); #1; handler_done = 1'b0;
    n = 0;
    got.delete();
    while (got.size() < 3 && n < 50) begin
      @(negedge clk_in);
      if (tx_valid && tx_ready) got.push_back(tx_byte);
      n++;
    end
    chk("rst_mid_bytes_seen", got.size(), 3);
    @(posedge clk_in); #2;
    rst_n_in = 1'b0;
    #1;
    chk("rst_mid_outs", {tx_valid, tx_byte, reg_rd_en, reg_rd_idx, busy, frame_done}, 0);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    run_frame(vecs[2]);
    check_frame(vecs[2], "after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/modbus_tx_framer.md
MODBUS_TX_FRAMER -- requirements
Module: modbus_tx_framer

Interface
REQ-001 SHALL have parameter SADDR, default 8'h01, slave address placed in byte 0 of every frame.
REQ-002 SHALL have parameter MAX_REGS, default 16, maximum register count for FC 03/04; legal range 1..125.
REQ-003 SHALL have port clk_in  input  1  system clock; all state on its rising edge.
REQ-004 SHALL have port rst_n_in  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port handler_done  input  1  one-cycle request pulse; operands valid in the same cycle.
REQ-006 SHALL have port exception  input  8  exception code; 8'h00 means normal response.
REQ-007 SHALL have port func_code  input  8  request function code.
REQ-008 SHALL have port addr  input  16  start register address (FC 06/10 echo).
REQ-009 SHALL have port data  input  16  written value (FC 06 echo).
REQ-010 SHALL have port quantity  input  8  register count (FC 03/04/10).
REQ-011 SHALL have port reg_rd_en  output  1  register-file read strobe.
REQ-012 SHALL have port reg_rd_idx  output  8  register offset from addr, 0..quantity-1.
REQ-013 SHALL have port reg_rd_data  input  16  read data, valid exactly 1 cycle after reg_rd_en.
REQ-014 SHALL have port tx_byte  output  8  frame byte to UART transmitter.
REQ-015 SHALL have port tx_valid  output  1  tx_byte valid.
REQ-016 SHALL have port tx_ready  input  1  transmitter accepts; a byte transfers when tx_valid && tx_ready.
REQ-017 SHALL have ports busy (output, 1, frame in progress) and frame_done (output, 1, one-cycle pulse after the last CRC byte transfers).

Function
REQ-018 SHALL capture all operands when handler_done=1 and busy=0; SHALL ignore handler_done while busy=1.
REQ-019 SHALL emit, for exception!=0: SADDR, func_code|8'h80, exception, CRC_lo, CRC_hi (5 bytes).
REQ-020 SHALL emit, for FC 06: SADDR, 06, addr[15:8], addr[7:0], data[15:8], data[7:0], CRC_lo, CRC_hi.
REQ-021 SHALL emit, for FC 10: SADDR, 10, addr hi, addr lo, 8'h00, quantity, CRC_lo, CRC_hi.
REQ-022 SHALL emit, for FC 03/04: SADDR, fc, 2*quantity (8-bit), then per register hi byte then lo byte, then CRC_lo, CRC_hi.
REQ-023 SHALL substitute exception 8'h03 when FC 03/04 has quantity 0 or >MAX_REGS, and 8'h01 for any other FC when exception=0.
REQ-024 SHALL compute CRC-16/Modbus (init 16'hFFFF, reflected poly 16'hA001) over all bytes preceding the CRC, updating once per transferred byte.
REQ-025 SHALL hold tx_byte stable while tx_valid=1 and tx_ready=0; no bubble requirement except one cycle per register fetch.
REQ-026 SHALL use states IDLE -> LOAD -> HDR (fixed bytes) -> [FETCH -> REG_HI -> REG_LO, repeat per register] -> CRC_LO -> CRC_HI -> DONE -> IDLE.
REQ-027 SHALL assert reg_rd_en for exactly one cycle per register in FETCH, in ascending reg_rd_idx order, and latch reg_rd_data on the following cycle.
REQ-028 SHALL assert busy from the cycle after the accepted handler_done through the DONE cycle; frame_done asserts in DONE.
REQ-029 SHALL accept a new handler_done in the cycle after DONE (busy=0).

Reset
REQ-030 SHALL, on rst_n_in=0 (including mid-frame), drive state IDLE, tx_valid=0, tx_byte=0, reg_rd_en=0, reg_rd_idx=0, busy=0, frame_done=0, CRC=16'hFFFF; partial frame is abandoned.

Structure
REQ-031 SHALL place function code constants (03,04,06,10), exception codes (01,03), CRC init/poly and state encoding in shared package modbus_pkg.
REQ-032 SHALL instantiate one sub-module modbus_crc16_byte: combinational 8-bit-per-call CRC update (crc_in, byte_in -> crc_out).

Verification
REQ-033 FC 06, addr 0001, data 0003, tx_ready=1 -> bytes 01 06 00 01 00 03 98 0B, frame_done once.
REQ-034 exception 02, func_code 03 -> bytes 01 83 02 C0 F1.
REQ-035 FC 03, quantity 2, regs 000A, 0102 -> 01 03 04 00 0A 01 02 + CRC equal to model; two reg_rd_en pulses, idx 0 then 1.
REQ-036 FC 03, quantity 0 and quantity MAX_REGS+1 -> 01 83 03 + CRC; no reg_rd_en.
REQ-037 random tx_ready stalls during FC 03 quantity MAX_REGS -> tx_byte stable under stall, byte sequence identical to unstalled run; handler_done mid-frame ignored.
REQ-038 rst_n_in asserted after byte 3 of a frame -> all outputs at reset values immediately; next request produces a complete correct frame.
